delay_seq_gen: RTL and testbench

- Parametrised successor to the single-output reset-release delay counter in the clock/reset generator (CRG).
- Releases NUM_CH enables in a fixed order (channel 0 first). Each channel has its own programmable delay, counted from the release of the previous channel.
- Supports software restart of the whole sequence. Reports busy/done status and gives a one-cycle strobe per channel release.
- Sits in the CRG and drives ordered release of downstream domain resets/enables.

---
 rtl/delay_seq_gen.sv | 122 ++++++++++++
 tb/tb_delay_seq_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_seq_gen.sv
// rtl/delay_seq_gen.sv - ordered release of NUM_CH enables, each after its own programmable delay
module delay_seq_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic                     start_i,
    input  logic [NUM_CH*CNT_W-1:0]  dly_i,
    output logic [NUM_CH-1:0]        ch_o,
    output logic [NUM_CH-1:0]        ch_pulse_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]      ch_q, ch_d;
    logic [NUM_CH-1:0]      pulse_q, pulse_d;
    logic [CNT_W-1:0]       dly_q [NUM_CH];
    logic [CNT_W-1:0]       dly_d [NUM_CH];
    logic [CNT_W-1:0]       cur_dly;
    logic [CNT_W-1:0]       eff;

    // A programmed delay of zero still costs one edge so every release is a distinct strobe.
    assign cur_dly = dly_q[idx_q];
    assign eff     = (cur_dly == '0) ? CNT_W'(1) : cur_dly;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        pulse_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            dly_d[k] = dly_q[k];
        end

        case (state_q)
            ST_LOAD: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    dly_d[k] = dly_i[k*CNT_W +: CNT_W];
                end
                cnt_d   = '0;
                idx_d   = '0;
                ch_d    = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Restart wins over a release falling on the same edge.
                if (start_i) begin
                    ch_d    = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end else if (cnt_q == eff - CNT_W'(1)) begin
                    ch_d[idx_q]    = 1'b1;
                    pulse_d[idx_q] = 1'b1;
                    cnt_d          = '0;
                    if (idx_q == IDX_W'(NUM_CH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    ch_d    = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
                ch_d    = '0;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
            pulse_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            pulse_q <= pulse_d;
            for (int k = 0; k < NUM_CH; k++) begin
                dly_q[k] <= dly_d[k];
            end
        end
    end

    assign ch_o       = ch_q;
    assign ch_pulse_o = pulse_q;
    assign done_o     = (state_q == ST_DONE);
    assign busy_o     = ~done_o;

endmodule

// File: tb/tb_delay_seq_gen.sv
// tb/tb_delay_seq_gen.sv - randomized and directed checks of delay_seq_gen against a cumulative-time model
module tb_delay_seq_gen;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk    = 1'b0;
    logic             arst_n = 1'b1;
    logic             start  = 1'b0;
    logic [N*W-1:0]   dly    = '0;
    logic [N-1:0]     ch_o;
    logic [N-1:0]     ch_pulse_o;
    logic             busy_o;
    logic             done_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    delay_seq_gen #(.NUM_CH(N), .CNT_W(W)) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .start_i    (start),
        .dly_i      (dly),
        .ch_o       (ch_o),
        .ch_pulse_o (ch_pulse_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    // Model: after a LOAD edge, channel k is up once the edge count reaches the running sum of effective delays.
    bit m_load = 1'b1;
    int m_t    = 0;
    int m_cum [N];
    int m_acc;
    int m_e;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_load = 1'b1;
            m_t    = 0;
        end else if (m_load) begin
            m_acc = 0;
            for (int k = 0; k < N; k++) begin
                m_e   = int'(dly[k*W +: W]);
                m_acc = m_acc + ((m_e == 0) ? 1 : m_e);
                m_cum[k] = m_acc;
            end
            m_load = 1'b0;
            m_t    = 0;
        end else if (start) begin
            m_load = 1'b1;
        end else begin
            m_t = m_t + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [N-1:0] e_ch;
        logic [N-1:0] e_pl;
        logic         e_done;
        for (int k = 0; k < N; k++) begin
            e_ch[k] = !m_load && (m_t >= m_cum[k]);
            e_pl[k] = !m_load && (m_t == m_cum[k]);
        end
        e_done = !m_load && (m_t >= m_cum[N-1]);
        chk("model_ch",    32'(ch_o),       32'(e_ch));
        chk("model_pulse", 32'(ch_pulse_o), 32'(e_pl));
        chk("model_done",  32'(done_o),     32'(e_done));
        chk("model_busy",  32'(busy_o),     32'(!e_done));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cmp_model();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        start  = 1'b0;
        arst_n = 1'b0;
        #1;
        chk("rst_ch",    32'(ch_o),       32'h0);
        chk("rst_pulse", 32'(ch_pulse_o), 32'h0);
        chk("rst_busy",  32'(busy_o),     32'h1);
        chk("rst_done",  32'(done_o),     32'h0);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
    endtask

    // Directed sequence for delays (3,1,0,5); optionally disturbs dly_i once the run is underway.
    task automatic seq1(input bit scramble);
        ticks(3);
        chk("s1_e3_ch", 32'(ch_o), 32'h0);
        if (scramble) dly = $urandom;
        tick();
        chk("s1_e4_ch", 32'(ch_o), 32'h1);
        chk("s1_e4_pl", 32'(ch_pulse_o), 32'h1);
        tick();
        chk("s1_e5_ch", 32'(ch_o), 32'h3);
        chk("s1_e5_pl", 32'(ch_pulse_o), 32'h2);
        tick();
        chk("s1_e6_ch", 32'(ch_o), 32'h7);
        chk("s1_e6_pl", 32'(ch_pulse_o), 32'h4);
        ticks(4);
        chk("s1_e10_ch",   32'(ch_o),   32'h7);
        chk("s1_e10_done", 32'(done_o), 32'h0);
        tick();
        chk("s1_e11_ch",   32'(ch_o),       32'hF);
        chk("s1_e11_pl",   32'(ch_pulse_o), 32'h8);
        chk("s1_e11_done", 32'(done_o),     32'h1);
        chk("s1_e11_busy", 32'(busy_o),     32'h0);
    endtask

    localparam logic [N*W-1:0] DLY_A = {8'd5, 8'd0, 8'd1, 8'd3};
    localparam logic [N*W-1:0] DLY_B = {8'd255, 8'd0, 8'd0, 8'd0};

    initial begin
        #1;
        dly = DLY_A;
        do_reset();
        seq1(1'b0);
        repeat (100) begin
            tick();
            chk("hold_ch",   32'(ch_o),       32'hF);
            chk("hold_done", 32'(done_o),     32'h1);
            chk("hold_pl",   32'(ch_pulse_o), 32'h0);
        end

        dly = DLY_B;
        do_reset();
        ticks(2);
        chk("zm_e2_ch", 32'(ch_o), 32'h1);
        tick();
        chk("zm_e3_ch", 32'(ch_o), 32'h3);
        tick();
        chk("zm_e4_ch", 32'(ch_o), 32'h7);
        ticks(254);
        chk("zm_e258_ch",   32'(ch_o),   32'h7);
        chk("zm_e258_done", 32'(done_o), 32'h0);
        tick();
        chk("zm_e259_ch",   32'(ch_o),   32'hF);
        chk("zm_e259_done", 32'(done_o), 32'h1);

        dly = DLY_A;
        do_reset();
        ticks(6);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rm_e7_ch",   32'(ch_o),   32'h0);
        chk("rm_e7_busy", 32'(busy_o), 32'h1);
        ticks(3);
        chk("rm_e10_ch", 32'(ch_o), 32'h0);
        tick();
        chk("rm_e11_ch", 32'(ch_o), 32'h1);
        ticks(6);
        chk("rm_e17_ch", 32'(ch_o), 32'h7);
        tick();
        chk("rm_e18_ch",   32'(ch_o),   32'hF);
        chk("rm_e18_done", 32'(done_o), 32'h1);

        do_reset();
        ticks(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("re_e4_ch", 32'(ch_o),       32'h0);
        chk("re_e4_pl", 32'(ch_pulse_o), 32'h0);
        ticks(3);
        chk("re_e7_ch", 32'(ch_o), 32'h0);
        tick();
        chk("re_e8_ch", 32'(ch_o), 32'h1);

        do_reset();
        ticks(5);
        #1;
        arst_n = 1'b0;
        #1;
        chk("ar_ch",   32'(ch_o),       32'h0);
        chk("ar_pl",   32'(ch_pulse_o), 32'h0);
        chk("ar_done", 32'(done_o),     32'h0);
        chk("ar_busy", 32'(busy_o),     32'h1);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        seq1(1'b1);

        repeat (40) begin
            for (int k = 0; k < N; k++) begin
                dly[k*W +: W] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                            : 8'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 7) == 0) do_reset();
            repeat (60) begin
                start = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0) dly = $urandom;
                if ($urandom_range(0, 99) == 0) begin
                    #1;
                    arst_n = 1'b0;
                    #1;
                    cmp_model();
                    @(posedge clk);
                    #2;
                    arst_n = 1'b1;
                end
                tick();
            end
            start = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
